// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave sequencing a 32-bit byte-enabled write-first SRAM with 1-cycle read latency.
// Reads and writes run back-to-back at zero wait; a read landing on a write data phase costs one wait.
module ahb_sram_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic [31:0]           hrdata,
  output logic                  hresp,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_enb,
  output logic [3:0]            ram_web,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA, RD_ISSUE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            mask;
  logic                  unused_ok;

  assign accept     = hsel & htrans[1] & hready;
  assign haddr_word = haddr[ADDR_WIDTH+1:2];
  assign hresp      = 1'b0;
  assign unused_ok  = &{1'b0, haddr[31:ADDR_WIDTH+2], htrans[0]};

  always_comb begin
    case (hsize)
      3'd0:    mask = 4'b0001 << haddr[1:0];
      3'd1:    mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  // addr_q serves both the pending write and a read deferred behind that write
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      mask_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= haddr_word;
        mask_q <= mask;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hrdata    = '0;
    ram_addr  = addr_q;
    ram_enb   = '0;
    ram_web   = '0;
    ram_din   = hwdata;
    case (state)
      IDLE, RD_DATA: begin
        if (state == RD_DATA) hrdata = ram_dout;
        state_nxt = IDLE;
        if (accept) begin
          if (hwrite) begin
            state_nxt = WR_DATA;
          end else begin
            state_nxt = RD_DATA;
            ram_addr  = haddr_word;
            ram_enb   = 4'hF;
          end
        end
      end
      WR_DATA: begin
        ram_enb = mask_q;
        ram_web = mask_q;
        // the RAM port is busy with the write, so a new read is replayed next cycle
        if (accept) state_nxt = hwrite ? WR_DATA : RD_ISSUE;
        else        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        hreadyout = 1'b0;
        ram_enb   = 4'hF;
        state_nxt = RD_DATA;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      hreadyout = 1'b1;
      hrdata    = '0;
      ram_enb   = '0;
      ram_web   = '0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Self-checking bench for ahb_sram_ctrl: directed vector table, reset corner cases and
// randomized AHB traffic checked against a byte-addressed memory model.
module tb_ahb_sram_ctrl;

  localparam int AW = 10;

  logic          clk, rst, hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0]   haddr, hwdata, hrdata, ram_din, ram_dout;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_enb, ram_web;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    bit          idle;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    bit          chk;
    logic [31:0] exp;
    bit          last;
    int          waits;
  } vec_t;

  vec_t tbl[$];
  vec_t ops[$];

  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] ram_word;
  logic [7:0]  mem_model [int];

  ahb_sram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hrdata(hrdata),
    .hresp(hresp), .ram_addr(ram_addr), .ram_enb(ram_enb), .ram_web(ram_web),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single slave on the bus, so the bus-level ready is this slave's ready
  assign hready = hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural write-first SRAM with one-cycle registered read
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 32'h0;
    ram_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (|ram_enb) begin
      ram_word = ram_mem[ram_addr];
      for (int l = 0; l < 4; l++)
        if (ram_enb[l] && ram_web[l]) ram_word[8*l +: 8] = ram_din[8*l +: 8];
      ram_mem[ram_addr] <= ram_word;
      ram_dout <= ram_word;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model keyed by aliased byte address; AHB size selects an aligned byte group
  function automatic void model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] base, b;
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    base = a & ~(32'(n) - 32'd1);
    for (int k = 0; k < n; k++) begin
      b = base + 32'(k);
      mem_model[int'(b & 32'hFFF)] = d[8*int'(b[1:0]) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    int key;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      key = int'((a & 32'hFFC) + 32'(k));
      if (mem_model.exists(key)) w[8*k +: 8] = mem_model[key];
    end
    return w;
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd2; hwdata = 32'h0;
  endtask

  // Acts as a pipelined AHB master over ops[]; entered and left just after a rising edge
  task automatic applyStimulus(output int waits);
    int   i = 0;
    int   guard = 0;
    bit   dp_valid = 0;
    bit   ready;
    vec_t dp;
    waits = 0;
    while (i < ops.size() || dp_valid) begin
      if (i < ops.size() && !ops[i].idle) begin
        hsel = 1'b1; htrans = 2'b10; hwrite = ops[i].write;
        haddr = ops[i].addr; hsize = ops[i].size;
      end else begin
        hsel = 1'($urandom);
        htrans = hsel ? {1'b0, 1'($urandom)} : 2'b10;
        hwrite = 1'($urandom); haddr = $urandom; hsize = 3'($urandom);
      end
      hwdata = (dp_valid && dp.write) ? dp.data : $urandom;
      @(negedge clk);
      ready = hreadyout;
      checkOutput("hresp", {31'h0, hresp}, 32'h0);
      if (!ready) waits++;
      if (ready && dp_valid && !dp.write) begin
        checkOutput(dp.chk ? "read_table" : "read_model", hrdata,
                    dp.chk ? dp.exp : model_read(dp.addr));
      end else begin
        checkOutput("hrdata_zero", hrdata, 32'h0);
      end
      if (ready && dp_valid && dp.write) model_write(dp.addr, dp.size, dp.data);
      if (ready) begin
        dp_valid = (i < ops.size()) && !ops[i].idle;
        if (i < ops.size()) begin
          dp = ops[i];
          i++;
        end
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        vec_count++;
        miscompares++;
        $display("[TB] FAIL timeout: sequence stuck, got %0d cycles, expected < 2000", guard);
        break;
      end
    end
    drive_idle();
  endtask

  function automatic vec_t mk(input bit idle, input bit wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [31:0] d, input bit chk,
                              input logic [31:0] exp, input bit last, input int waits);
    vec_t v;
    v.idle = idle; v.write = wr; v.addr = a; v.size = sz; v.data = d;
    v.chk = chk; v.exp = exp; v.last = last; v.waits = waits;
    return v;
  endfunction

  initial begin
    int w, exp_waits;
    vec_t v;

    // Directed vectors; the last record of each group carries the expected wait count
    tbl.push_back(mk(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h10, 3'd2, 0, 1, 32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(0, 1, 32'h21, 3'd0, 32'h0000AA00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h22, 3'd1, 32'h12340000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h20, 3'd2, 0, 1, 32'h1234AA00, 1, 0));
    tbl.push_back(mk(0, 1, 32'h40, 3'd2, 32'hCAFEF00D, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h40, 3'd2, 0, 1, 32'hCAFEF00D, 1, 1));
    tbl.push_back(mk(0, 1, 32'h00, 3'd2, 32'h11111111, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h04, 3'd2, 32'h22222222, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h08, 3'd2, 32'h33333333, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h0C, 3'd2, 32'h44444444, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h00, 3'd2, 0, 1, 32'h11111111, 0, 0));
    tbl.push_back(mk(0, 0, 32'h04, 3'd2, 0, 1, 32'h22222222, 0, 0));
    tbl.push_back(mk(0, 0, 32'h08, 3'd2, 0, 1, 32'h33333333, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0C, 3'd2, 0, 1, 32'h44444444, 1, 0));
    tbl.push_back(mk(0, 1, 32'h23, 3'd1, 32'h5678FFFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h20, 3'd2, 0, 1, 32'h5678AA00, 1, 0));
    tbl.push_back(mk(0, 1, 32'h60, 3'd3, 32'hA5A5A5A5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h1070, 3'd7, 32'h0BADF00D, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h60, 3'd2, 0, 1, 32'hA5A5A5A5, 0, 0));
    tbl.push_back(mk(0, 0, 32'hF070, 3'd2, 0, 1, 32'h0BADF00D, 1, 0));
    tbl.push_back(mk(0, 1, 32'h50, 3'd2, 32'h11223344, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h50, 3'd2, 0, 1, 32'h11223344, 1, 0));

    drive_idle();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
      checkOutput("rst_hrdata", hrdata, 32'h0);
      checkOutput("rst_ram_enb", {28'h0, ram_enb}, 32'h0);
      checkOutput("rst_ram_web", {28'h0, ram_web}, 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      ops.push_back(tbl[k]);
      if (tbl[k].last) begin
        applyStimulus(w);
        checkOutput("wait_cycles", 32'(w), 32'(tbl[k].waits));
        ops.delete();
      end
    end

    // Reset during the data phase of a write must drop that write
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h50; hsize = 3'd2;
    @(posedge clk);
    #1 rst = 1'b1;
    drive_idle();
    hwdata = 32'h55555555;
    @(negedge clk);
    checkOutput("wrrst_ram_web", {28'h0, ram_web}, 32'h0);
    checkOutput("wrrst_ram_enb", {28'h0, ram_enb}, 32'h0);
    checkOutput("wrrst_hreadyout", {31'h0, hreadyout}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_ram_web", {28'h0, ram_web}, 32'h0);
    checkOutput("postrst_ram_enb", {28'h0, ram_enb}, 32'h0);
    @(posedge clk);
    #1;
    ops.push_back(mk(0, 0, 32'h50, 3'd2, 0, 1, 32'h11223344, 1, 0));
    applyStimulus(w);
    checkOutput("wrrst_waits", 32'(w), 32'h0);
    ops.delete();

    // Random traffic in chunks; a read directly after a write costs exactly one wait
    for (int chunk = 0; chunk < 15; chunk++) begin
      exp_waits = 0;
      for (int n = 0; n < 20; n++) begin
        int r;
        r = $urandom_range(0, 9);
        v = mk(r < 2, r < 6, ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63)),
               3'($urandom_range(0, 7)), $urandom, 0, 0, 0, 0);
        if (n > 0 && !v.idle && !v.write && !ops[n-1].idle && ops[n-1].write) exp_waits++;
        ops.push_back(v);
      end
      applyStimulus(w);
      checkOutput("rand_waits", 32'(w), 32'(exp_waits));
      ops.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
